// File: rtl/shade_stream_packer.sv
// Packs 24-bit shaded pixels four-at-a-time into three 32-bit AXI4-Stream video words,
// tracking raster position to mark start-of-frame (tuser), end-of-line (tlast) and frame completion.
module shade_stream_packer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int PIX_W  = 24,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  s_pixel,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [WORD_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              frame_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;

  logic [1:0]        phase_q, phase_d;
  logic [PIX_W-1:0]  hold_q, hold_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [WORD_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tuser_q, tuser_d;
  logic              tlast_q, tlast_d;
  logic              eof_q, eof_d;
  logic              done_q, done_d;
  logic              accept_s;
  logic              xfer_s;
  logic [WORD_W-1:0] word_s;

  // Phase 0 only stores a pixel, so it may proceed even while the output word is stalled.
  assign s_ready  = (phase_q == PH0) | ~tvalid_q | m_tready;
  assign accept_s = s_valid & s_ready;
  assign xfer_s   = tvalid_q & m_tready;

  // Word assembly from the previously held pixel and the incoming one.
  always_comb begin
    word_s = {WORD_W{1'b0}};
    case (phase_q)
      PH1:     word_s = {s_pixel[7:0], hold_q[23:0]};
      PH2:     word_s = {s_pixel[15:0], hold_q[23:8]};
      PH3:     word_s = {s_pixel[23:0], hold_q[23:16]};
      default: word_s = {WORD_W{1'b0}};
    endcase
  end

  // Next-state for phase, raster position and the single output register.
  always_comb begin
    phase_d  = phase_q;
    hold_d   = hold_q;
    x_d      = x_q;
    y_d      = y_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    eof_d    = eof_q;
    done_d   = xfer_s & eof_q;

    if (accept_s) begin
      hold_d  = s_pixel;
      phase_d = phase_q + 2'd1;
      if (x_q == X_LAST) begin
        x_d = {XW{1'b0}};
        y_d = (y_q == Y_LAST) ? {YW{1'b0}} : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end else begin
      hold_d = hold_q;
    end

    // A load always wins over a plain transfer; s_ready guarantees the old word is leaving.
    if (accept_s && (phase_q != PH0)) begin
      tdata_d  = word_s;
      tvalid_d = 1'b1;
      tuser_d  = (phase_q == PH1) && (x_q == XW'(1)) && (y_q == {YW{1'b0}});
      tlast_d  = (phase_q == PH3) && (x_q == X_LAST);
      eof_d    = (phase_q == PH3) && (x_q == X_LAST) && (y_q == Y_LAST);
    end else if (xfer_s) begin
      tvalid_d = 1'b0;
      eof_d    = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH0;
      hold_q   <= {PIX_W{1'b0}};
      x_q      <= {XW{1'b0}};
      y_q      <= {YW{1'b0}};
      tdata_q  <= {WORD_W{1'b0}};
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      eof_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      hold_q   <= hold_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      eof_q    <= eof_d;
      done_q   <= done_d;
    end
  end

  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign m_tuser    = tuser_q;
  assign m_tlast    = tlast_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_shade_stream_packer.sv
// Directed/table-driven bench for shade_stream_packer with an 8x2 frame and a packing scoreboard.
module tb_shade_stream_packer;
  localparam int H = 8;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tuser;
  logic        m_tlast;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  shade_stream_packer #(.H_RES(H), .V_RES(V), .PIX_W(24), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tuser(m_tuser),
    .m_tlast(m_tlast), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold s_valid with pix until accepted (bounded); s_valid stays 1 on return.
  task automatic push_pixel(input logic [23:0] pix);
    logic acc;
    s_pixel = pix;
    s_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #1;
      acc = s_ready;
      tick();
      if (acc) return;
    end
    chk("push_timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard: packs accepted pixels independently and compares every transferred word.
  typedef struct { logic [31:0] d; logic u; logic l; logic eof; } word_t;
  word_t       exp_q[$];
  logic [1:0]  m_phase;
  logic [23:0] m_hold;
  int          m_idx;
  logic        fd_exp;

  initial begin
    word_t w;
    logic  fd_next;
    m_phase = 2'd0; m_hold = 24'd0; m_idx = 0; fd_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_phase = 2'd0; m_idx = 0; fd_exp = 1'b0;
      end else begin
        chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        fd_next = 1'b0;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", m_tdata, 32'hFFFF_FFFF);
          end else begin
            w = exp_q.pop_front();
            chk("sb_tdata", m_tdata, w.d);
            chk("sb_tuser", {31'd0, m_tuser}, {31'd0, w.u});
            chk("sb_tlast", {31'd0, m_tlast}, {31'd0, w.l});
            fd_next = w.eof;
          end
        end
        if (s_valid && s_ready) begin
          w.u = (m_idx == 1);
          w.l = ((m_idx % H) == H - 1);
          w.eof = (m_idx == H * V - 1);
          case (m_phase)
            2'd1: begin w.d = {s_pixel[7:0], m_hold}; exp_q.push_back(w); end
            2'd2: begin w.d = {s_pixel[15:0], m_hold[23:8]}; exp_q.push_back(w); end
            2'd3: begin w.d = {s_pixel, m_hold[23:16]}; exp_q.push_back(w); end
            default: ;
          endcase
          m_hold  = s_pixel;
          m_phase = m_phase + 2'd1;
          m_idx   = (m_idx + 1) % (H * V);
        end
        fd_exp = fd_next;
      end
    end
  end

  typedef struct {
    logic [23:0] pix;
    logic        exp_v;
    logic [31:0] exp_data;
    logic        exp_user;
    logic        exp_last;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int   acc_cnt;
    int   got;
    logic acc;

    tbl[0]  = '{24'h112233, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[1]  = '{24'h445566, 1'b1, 32'h6611_2233, 1'b1, 1'b0};
    tbl[2]  = '{24'h778899, 1'b1, 32'h8899_4455, 1'b0, 1'b0};
    tbl[3]  = '{24'hAABBCC, 1'b1, 32'hAABB_CC77, 1'b0, 1'b0};
    tbl[4]  = '{24'h040404, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[5]  = '{24'h050505, 1'b1, 32'h0504_0404, 1'b0, 1'b0};
    tbl[6]  = '{24'h060606, 1'b1, 32'h0606_0505, 1'b0, 1'b0};
    tbl[7]  = '{24'h070707, 1'b1, 32'h0707_0706, 1'b0, 1'b1};
    tbl[8]  = '{24'h080808, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9]  = '{24'h090909, 1'b1, 32'h0908_0808, 1'b0, 1'b0};
    tbl[10] = '{24'h0A0A0A, 1'b1, 32'h0A0A_0909, 1'b0, 1'b0};
    tbl[11] = '{24'h0B0B0B, 1'b1, 32'h0B0B_0B0A, 1'b0, 1'b0};
    tbl[12] = '{24'h0C0C0C, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[13] = '{24'h0D0D0D, 1'b1, 32'h0D0C_0C0C, 1'b0, 1'b0};
    tbl[14] = '{24'h0E0E0E, 1'b1, 32'h0E0E_0D0D, 1'b0, 1'b0};
    tbl[15] = '{24'h0F0F0F, 1'b1, 32'h0F0F_0F0E, 1'b0, 1'b1};

    rst = 1'b1; s_valid = 1'b0; s_pixel = 24'd0; m_tready = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tuser", {31'd0, m_tuser}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    rst = 1'b0;

    // Packing and full frame from the table, one pixel per clock.
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_pixel = tbl[i].pix;
      s_valid = 1'b1;
      #1;
      chk("tbl_s_ready", {31'd0, s_ready}, 32'd1);
      tick();
      chk("tbl_tvalid", {31'd0, m_tvalid}, {31'd0, tbl[i].exp_v});
      if (tbl[i].exp_v) begin
        chk("tbl_tdata", m_tdata, tbl[i].exp_data);
        chk("tbl_tuser", {31'd0, m_tuser}, {31'd0, tbl[i].exp_user});
        chk("tbl_tlast", {31'd0, m_tlast}, {31'd0, tbl[i].exp_last});
      end
    end
    s_valid = 1'b0;
    tick();
    chk("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    chk("idle_tvalid", {31'd0, m_tvalid}, 32'd0);
    tick();
    chk("frame_done_single", {31'd0, frame_done}, 32'd0);

    // Backpressure: stall right after a phase-3 load; only the phase-0 pixel may enter.
    push_pixel(24'hA1A2A3);
    push_pixel(24'hB1B2B3);
    push_pixel(24'hC1C2C3);
    push_pixel(24'hD1D2D3);
    m_tready = 1'b0;
    s_pixel  = 24'hE1E2E3;
    acc_cnt  = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      acc = s_valid & s_ready;
      if (acc) acc_cnt++;
      tick();
      if (acc) s_pixel = 24'hF1F2F3;
      chk("stall_tvalid", {31'd0, m_tvalid}, 32'd1);
      chk("stall_tdata", m_tdata, 32'hD1D2_D3C1);
      chk("stall_tuser", {31'd0, m_tuser}, 32'd0);
      chk("stall_tlast", {31'd0, m_tlast}, 32'd0);
    end
    chk("stall_accepts", acc_cnt, 32'd1);
    m_tready = 1'b1;
    for (int k = 5; k < 16; k++) push_pixel(24'h300000 + 24'(k * 24'h010203));
    s_valid = 1'b0;

    // Random valid/ready over three frames.
    got = 0;
    for (int c = 0; c < 3000 && got < 48; c++) begin
      s_pixel  = 24'($urandom);
      s_valid  = 1'($urandom_range(0, 1));
      m_tready = 1'($urandom_range(0, 1));
      #1;
      if (s_valid && s_ready) got++;
      tick();
    end
    chk("random_pixels", got, 32'd48);
    s_valid = 1'b0;
    m_tready = 1'b1;
    repeat (4) tick();

    // Reset after six pixels of a frame.
    for (int k = 0; k < 6; k++) push_pixel(24'h500000 + 24'(k));
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("mid_rst_tdata", m_tdata, 32'd0);
    chk("mid_rst_tuser", {31'd0, m_tuser}, 32'd0);
    chk("mid_rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    push_pixel(24'h123456);
    push_pixel(24'h789ABC);
    chk("post_rst_tdata", m_tdata, 32'hBC12_3456);
    chk("post_rst_tuser", {31'd0, m_tuser}, 32'd1);
    for (int k = 2; k < 16; k++) push_pixel(24'h600000 + 24'(k));

    // Back-to-back frames without idle cycles.
    for (int k = 0; k < 32; k++) begin
      s_pixel = 24'h700000 + 24'(k * 24'h000111);
      s_valid = 1'b1;
      #1;
      chk("b2b_s_ready", {31'd0, s_ready}, 32'd1);
      tick();
    end
    s_valid = 1'b0;

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    repeat (2) tick();
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
